// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: streams sequential reads from a one-cycle-latency ROM into a small
// FIFO of {pc, instruction} entries, with redirect-driven flush and credit-based flow control.
module instruction_prefetch #(
    parameter int unsigned PC_WIDTH          = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned DEPTH             = 4
) (
    input  logic                         clock,
    input  logic                         isResetN,
    output logic                         fetchReq,
    output logic [PC_WIDTH-1:0]          fetchAddr,
    input  logic [INSTRUCTION_WIDTH-1:0] romData,
    input  logic                         redirect,
    input  logic [PC_WIDTH-1:0]          redirectPc,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instructionPc,
    output logic                         instructionValid,
    input  logic                         instructionReady,
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PC_WIDTH-1:0]          fetch_pc_q;
    logic                         in_flight_q;
    logic [PC_WIDTH-1:0]          tag_q;
    logic [PtrW-1:0]              wr_ptr_q;
    logic [PtrW-1:0]              rd_ptr_q;
    logic [CntW-1:0]              count_q;
    logic [PC_WIDTH-1:0]          pc_mem   [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] data_mem [DEPTH];

    logic [CntW-1:0] credit_used;
    logic            push;
    logic            pop;

    // Every outstanding read owns a slot; a same-cycle pop earns no credit.
    assign credit_used = count_q + CntW'(in_flight_q);
    assign fetchReq    = isResetN && !redirect && (credit_used < CntW'(DEPTH));
    assign fetchAddr   = fetch_pc_q;

    // A redirect kills the response arriving this cycle.
    assign push = in_flight_q && !redirect;
    assign pop  = instructionValid && instructionReady;

    assign instructionValid = (count_q != '0);
    assign instruction      = data_mem[rd_ptr_q];
    assign instructionPc    = pc_mem[rd_ptr_q];
    assign occupancy        = count_q;

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            fetch_pc_q  <= '0;
            in_flight_q <= 1'b0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            in_flight_q <= fetchReq;
            tag_q       <= fetch_pc_q;
            if (redirect) begin
                fetch_pc_q <= redirectPc;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (fetchReq) begin
                    fetch_pc_q <= fetch_pc_q + 1'b1;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_q + CntW'(push) - CntW'(pop);
            end
        end
    end

    // Storage needs no reset: the head is only meaningful while count_q is non-zero.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= tag_q;
            data_mem[wr_ptr_q] <= romData;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: fill, backpressure, redirect, wrap and reset scenarios
// against a one-cycle-latency ROM model.
module tb_instruction_prefetch;

    logic        clock;
    logic        isResetN;
    logic        fetchReq;
    logic [7:0]  fetchAddr;
    logic [31:0] romData;
    logic        redirect;
    logic [7:0]  redirectPc;
    logic [31:0] instruction;
    logic [7:0]  instructionPc;
    logic        instructionValid;
    logic        instructionReady;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    instruction_prefetch #(
        .PC_WIDTH          (8),
        .INSTRUCTION_WIDTH (32),
        .DEPTH             (4)
    ) dut (
        .clock            (clock),
        .isResetN         (isResetN),
        .fetchReq         (fetchReq),
        .fetchAddr        (fetchAddr),
        .romData          (romData),
        .redirect         (redirect),
        .redirectPc       (redirectPc),
        .instruction      (instruction),
        .instructionPc    (instructionPc),
        .instructionValid (instructionValid),
        .instructionReady (instructionReady),
        .occupancy        (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM word carries its address in the low byte plus a fixed tag pattern above it.
    function automatic logic [31:0] rom_word(input logic [7:0] addr);
        return {24'h5A5A5A, addr};
    endfunction

    always @(posedge clock) begin
        romData <= fetchReq ? rom_word(fetchAddr) : 32'hDEADBEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic exp_valid, input logic [7:0] exp_pc);
        chk({tag, "_valid"}, 64'(instructionValid), 64'(exp_valid));
        if (exp_valid) begin
            chk({tag, "_pc"}, 64'(instructionPc), 64'(exp_pc));
            chk({tag, "_instr"}, 64'(instruction), 64'(rom_word(exp_pc)));
        end
    endtask

    initial begin
        isResetN         = 1'b0;
        redirect         = 1'b0;
        redirectPc       = 8'h00;
        instructionReady = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req", 64'(fetchReq), 64'd0);
        chk("rst_valid", 64'(instructionValid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_addr", 64'(fetchAddr), 64'd0);

        // Streaming with ready held high: one instruction per cycle after a 2-cycle fill.
        @(negedge clock);
        isResetN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stream_req", 64'(fetchReq), 64'd1);
            chk("stream_addr", 64'(fetchAddr), 64'(k));
            chk("stream_occ", 64'(occupancy), (k >= 2) ? 64'd1 : 64'd0);
            chk_head("stream", k >= 2, 8'(k - 2));
            @(negedge clock);
        end

        // Mid-stream reset: valid must fall without waiting for a clock edge.
        isResetN = 1'b0;
        #1;
        chk("midrst_valid", 64'(instructionValid), 64'd0);
        chk("midrst_req", 64'(fetchReq), 64'd0);
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_addr", 64'(fetchAddr), 64'd0);
        @(negedge clock);
        instructionReady = 1'b0;
        @(negedge clock);
        isResetN = 1'b1;

        // Backpressure from reset: four requests fill the FIFO, head stays at pc 0.
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("bp_req", 64'(fetchReq), (k <= 3) ? 64'd1 : 64'd0);
            chk("bp_addr", 64'(fetchAddr), (k <= 4) ? 64'(k) : 64'd4);
            chk("bp_occ", 64'(occupancy), (k <= 1) ? 64'd0 : ((k >= 5) ? 64'd4 : 64'(k - 1)));
            chk_head("bp", k >= 2, 8'h00);
            @(negedge clock);
        end

        // Drain in order once ready rises.
        instructionReady = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk_head("drain", 1'b1, 8'(j));
            if (j == 0) chk("drain_occ0", 64'(occupancy), 64'd4);
            if (j == 1) chk("drain_occ1", 64'(occupancy), 64'd3);
            if (j >= 2) chk("drain_occ", 64'(occupancy), 64'd2);
            @(negedge clock);
        end

        // Queue a third entry, then redirect to 0x40.
        instructionReady = 1'b0;
        #1;
        chk("q3_occ_before", 64'(occupancy), 64'd2);
        @(negedge clock);
        redirect   = 1'b1;
        redirectPc = 8'h40;
        #1;
        chk("redir_occ_n", 64'(occupancy), 64'd3);
        chk("redir_req_n", 64'(fetchReq), 64'd0);
        @(negedge clock);
        redirect         = 1'b0;
        instructionReady = 1'b1;
        #1;
        chk("redir_occ_n1", 64'(occupancy), 64'd0);
        chk("redir_req_n1", 64'(fetchReq), 64'd1);
        chk("redir_addr_n1", 64'(fetchAddr), 64'h40);
        chk_head("redir_n1", 1'b0, 8'h00);
        @(negedge clock);
        #1;
        chk("redir_addr_n2", 64'(fetchAddr), 64'h41);
        chk_head("redir_n2", 1'b0, 8'h00);
        @(negedge clock);
        #1;
        chk_head("redir_n3", 1'b1, 8'h40);
        @(negedge clock);
        #1;
        chk_head("redir_n4", 1'b1, 8'h41);

        // Redirect near the top of the address space: fetch pc wraps silently.
        @(negedge clock);
        redirect   = 1'b1;
        redirectPc = 8'hFE;
        #1;
        chk("wrap_req_m", 64'(fetchReq), 64'd0);
        @(negedge clock);
        redirect = 1'b0;
        #1;
        chk("wrap_addr_m1", 64'(fetchAddr), 64'hFE);
        @(negedge clock);
        #1;
        chk("wrap_addr_m2", 64'(fetchAddr), 64'hFF);
        @(negedge clock);
        #1;
        chk("wrap_addr_m3", 64'(fetchAddr), 64'h00);
        chk_head("wrap_m3", 1'b1, 8'hFE);
        @(negedge clock);
        #1;
        chk_head("wrap_m4", 1'b1, 8'hFF);
        @(negedge clock);
        #1;
        chk_head("wrap_m5", 1'b1, 8'h00);
        @(negedge clock);
        #1;
        chk_head("wrap_m6", 1'b1, 8'h01);

        // Back-to-back redirects: only 0x20 survives.
        @(negedge clock);
        redirect   = 1'b1;
        redirectPc = 8'h10;
        #1;
        chk("b2b_req_n", 64'(fetchReq), 64'd0);
        @(negedge clock);
        redirectPc = 8'h20;
        #1;
        chk("b2b_req_n1", 64'(fetchReq), 64'd0);
        chk_head("b2b_n1", 1'b0, 8'h00);
        @(negedge clock);
        redirect = 1'b0;
        #1;
        chk("b2b_req_n2", 64'(fetchReq), 64'd1);
        chk("b2b_addr_n2", 64'(fetchAddr), 64'h20);
        chk_head("b2b_n2", 1'b0, 8'h00);
        @(negedge clock);
        #1;
        chk_head("b2b_n3", 1'b0, 8'h00);
        @(negedge clock);
        #1;
        chk_head("b2b_n4", 1'b1, 8'h20);
        @(negedge clock);
        #1;
        chk_head("b2b_n5", 1'b1, 8'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of every program-counter value.
REQ-002 Parameter INSTRUCTION_WIDTH, default 32, width of one instruction word.
REQ-003 Parameter DEPTH, default 4, number of prefetch FIFO entries; power of two, >= 2.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 isResetN  input  1  reset, asynchronous, active-low.
REQ-006 fetchReq  output  1  high: instruction memory reads fetchAddr this cycle.
REQ-007 fetchAddr  output  PC_WIDTH  address of the read requested by fetchReq.
REQ-008 romData  input  INSTRUCTION_WIDTH  memory read data, valid exactly one cycle after fetchReq.
REQ-009 redirect  input  1  one-cycle pulse from the execute stage (JUMP, CALL, EXIT, taken IF0JUMP/IF1JUMP).
REQ-010 redirectPc  input  PC_WIDTH  new fetch address, sampled when redirect is high.
REQ-011 instruction  output  INSTRUCTION_WIDTH  head-of-FIFO instruction word.
REQ-012 instructionPc  output  PC_WIDTH  address the head instruction was fetched from.
REQ-013 instructionValid  output  1  head entry is valid.
REQ-014 instructionReady  input  1  consumer accepts the head entry this cycle.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of valid FIFO entries.

Function
REQ-016 State: fetchPc, FIFO of {pc, instruction} entries, occupancy count, inFlight flag with its address tag.
REQ-017 fetchReq is high when redirect is low and (occupancy + inFlight) < DEPTH; both terms are taken from registered state, so a pop in the same cycle earns no credit.
REQ-018 fetchAddr equals fetchPc at all times.
REQ-019 When fetchReq is high, fetchPc advances by 1 modulo 2^PC_WIDTH: the maximum value wraps to 0 with no flag.
REQ-020 When fetchReq is high, inFlight is set for the next cycle and tagged with fetchAddr; otherwise inFlight clears.
REQ-021 In a cycle where inFlight is set and the response is not killed, {tag, romData} is written to the FIFO tail at the clock edge ending that cycle.
REQ-022 A write is visible at the head no earlier than the next cycle: latency from fetchReq to instructionValid is 2 cycles, with no bypass.
REQ-023 A transfer occurs when instructionValid and instructionReady are both high; the head then pops at that edge.
REQ-024 While instructionValid is high and instructionReady is low, instruction and instructionPc hold stable.
REQ-025 A simultaneous push and pop leaves occupancy unchanged and preserves order.
REQ-026 The FIFO never overflows: the credit rule in REQ-017 guarantees a free slot for every response.
REQ-027 When occupancy is 0, instructionValid is low and instruction and instructionPc are don't-care.
REQ-028 Redirect has priority over all other events in its cycle:
- flush the FIFO (occupancy goes to 0 at that edge);
- kill any response in flight in that cycle or issued in the preceding cycle;
- load fetchPc with redirectPc;
- hold fetchReq low.
REQ-029 In the cycle after a redirect, fetchReq is high with fetchAddr = redirectPc; the first post-redirect instructionValid appears 3 cycles after the redirect cycle.
REQ-030 A transfer in a redirect cycle still counts as consumed by the downstream stage; the flush discards everything else.
REQ-031 Back-to-back redirects: only the last redirectPc takes effect, and each redirect restarts the REQ-029 timing.
REQ-032 Steady state with instructionReady held high: one instruction per cycle after the 2-cycle fill.

Reset
REQ-033 Asserting isResetN low immediately clears occupancy, inFlight, fetchPc (to 0) and instructionValid; fetchReq drives 0 while reset is held.
REQ-034 In the first cycle after deassertion, fetchReq is high with fetchAddr 0.
REQ-035 Reset asserted mid-operation discards all FIFO contents and in-flight responses, with no partial write.

Verification
REQ-036 Reset release, ready=1, ROM[n]=n: fetchAddr 0,1,2,... one per cycle; instructionValid from cycle 2; instructionPc/instruction = 0/0, 1/1, ... with no gaps.
REQ-037 ready=0 from reset: fetchReq stops after 4 requests, occupancy=4; head stays pc 0; ready=1 then drains 0,1,2,3,4,... in order.
REQ-038 Redirect to 0x40 in cycle N with 3 entries queued: occupancy=0 at N+1; fetchAddr=0x40 at N+1; first instructionPc=0x40 valid at N+3; no stale pc is ever presented.
REQ-039 Redirect to 0xFE, ready=1: instructionPc sequence 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
REQ-040 Redirects in cycles N and N+1 (to 0x10 then 0x20): no 0x10 entry is ever presented; first valid is 0x20 at N+4.
REQ-041 isResetN pulsed low mid-stream: instructionValid falls asynchronously; after release, fetching restarts at 0 per REQ-034.
